instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/risc_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 82 ++++++++
 tb/tb_instr_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the small RISC core: datapath widths and the 4-bit
// opcode map used by decode.
package risc_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;

  // ALU operations occupy 0000-0111; memory operations follow.
  localparam logic [3:0] OP_ALU_FIRST = 4'b0000;
  localparam logic [3:0] OP_ALU_LAST  = 4'b0111;
  localparam logic [3:0] OP_LOAD      = 4'b1000;
  localparam logic [3:0] OP_STORE     = 4'b1001;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op[3] == 1'b0;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO with flush, occupancy count and
// a registered head entry. Storage is deliberately left unreset.
module fetch_fifo
  import risc_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 12,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_en;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_en    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (pop_en) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  push_not_full: assert property (@(posedge clk) disable iff (!reset)
    (push && !flush) |-> (count < CNT_W'(DEPTH)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential PC, one-outstanding request to a
// synchronous instruction memory, and a prefetch buffer toward decode.
module instr_fetch_unit #(
  parameter  int ADDR_W  = risc_pkg::ADDR_W,
  parameter  int INSTR_W = risc_pkg::INSTR_W,
  parameter  int DEPTH   = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [CNT_W-1:0]   fifo_count
);

  import risc_pkg::*;

  localparam int ENTRY_W = ADDR_W + INSTR_W;

  // out_valid/out_ready: the head entry transfers on every rising edge where
  // both are high; out_valid never depends on out_ready and, once raised,
  // holds with stable out_pc/out_instr until it transfers or a redirect/reset.
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               inflight;
  logic               pop;
  logic [CNT_W:0]     occupancy;
  logic [ENTRY_W-1:0] head;

  // The slot freed by this cycle's pop is counted, giving back-to-back fetch
  // with a two-entry buffer while still never overfilling it.
  always_comb begin
    pop       = out_valid && out_ready;
    occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    imem_req  = reset && !halt && !redirect_valid &&
                (occupancy < (CNT_W + 1)'(DEPTH));
    imem_addr = fetch_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= '0;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        req_pc   <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (inflight),
    .push_data ({req_pc, imem_rdata}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count)
  );

  assign out_valid           = (fifo_count != '0);
  assign {out_pc, out_instr} = head;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// traffic compared every cycle against a timestamped transaction model.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;
  localparam int DEPTH   = 2;
  localparam int NPC     = 1 << ADDR_W;

  logic               clk;
  logic               reset;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [1:0]         fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [INSTR_W-1:0] mem [NPC];

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fifo_count     (fifo_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory; garbage when not requested so a design
  // that forwards imem_rdata instead of buffered data is exposed.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
    else          imem_rdata <= INSTR_W'($urandom);
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare ----------------
  // Every fetched address is a queue entry stamped with the cycle it becomes
  // visible (request cycle + 2). Queue length = buffered + in flight.
  typedef struct {
    int pc;
    int avail;
  } ent_t;

  ent_t q[$];
  int   m_pc = 0;
  int   cyc  = 0;

  always @(negedge clk) begin : cmp
    int n_av;
    bit hv;
    bit pp;
    bit er;
    if (!reset) begin
      q.delete();
      m_pc = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_fifo_count", int'(fifo_count), 0);
      chk("rst_imem_req", int'(imem_req), 0);
    end else begin
      n_av = 0;
      foreach (q[i]) if (q[i].avail <= cyc) n_av++;
      hv = (n_av > 0);
      pp = hv && out_ready;
      er = !halt && !redirect_valid && ((q.size() - int'(pp)) < DEPTH);
      chk("m_imem_req", int'(imem_req), int'(er));
      if (er) chk("m_imem_addr", int'(imem_addr), m_pc);
      chk("m_out_valid", int'(out_valid), int'(hv));
      chk("m_fifo_count", int'(fifo_count), n_av);
      if (hv) begin
        chk("m_out_pc", int'(out_pc), q[0].pc);
        chk("m_out_instr", int'(out_instr), int'(mem[q[0].pc]));
      end
      if (redirect_valid) begin
        q.delete();
        m_pc = int'(redirect_pc);
      end else begin
        if (pp) void'(q.pop_front());
        if (er) begin
          q.push_back('{pc: m_pc, avail: cyc + 2});
          m_pc = (m_pc + 1) % NPC;
        end
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int last_addr;
    int delivered;

    reset          = 1'b0;
    out_ready      = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem[0] = 8'h21;
    mem[1] = 8'h32;
    mem[2] = 8'h06;
    for (int i = 3; i < NPC; i++) mem[i] = INSTR_W'($urandom_range(0, 255));

    repeat (3) @(posedge clk);
    at_sample();
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_imem_req", int'(imem_req), 0);

    // Basic stream from address 0.
    step(); reset = 1'b1; out_ready = 1'b1;
    at_sample();
    chk("c0_req", int'(imem_req), 1);
    chk("c0_addr", int'(imem_addr), 0);
    chk("c0_valid", int'(out_valid), 0);
    step(); at_sample();
    chk("c1_addr", int'(imem_addr), 1);
    chk("c1_valid", int'(out_valid), 0);
    step(); at_sample();
    chk("c2_valid", int'(out_valid), 1);
    chk("c2_pc", int'(out_pc), 0);
    chk("c2_instr", int'(out_instr), 'h21);
    step(); at_sample();
    chk("c3_pc", int'(out_pc), 1);
    chk("c3_instr", int'(out_instr), 'h32);
    step(); at_sample();
    chk("c4_pc", int'(out_pc), 2);
    chk("c4_instr", int'(out_instr), 'h06);

    // Back-pressure: buffer fills to DEPTH and requests stop.
    step(); out_ready = 1'b0;
    repeat (5) step();
    at_sample();
    chk("bp_count", int'(fifo_count), 2);
    chk("bp_req", int'(imem_req), 0);
    chk("bp_head_pc", int'(out_pc), 3);
    step(); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_sample();
      chk("bp_order_valid", int'(out_valid), 1);
      chk("bp_order_pc", int'(out_pc), 3 + i);
      step();
    end

    // Address wrap after a redirect to 14.
    redirect_valid = 1'b1; redirect_pc = 4'd14;
    step(); redirect_valid = 1'b0;
    at_sample();
    chk("wrap_first_addr", int'(imem_addr), 14);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      at_sample();
      chk("wrap_pc", int'(out_pc), (14 + i) % NPC);
      step();
    end

    // Redirect to 9 while the buffer is full.
    out_ready = 1'b0;
    repeat (3) step();
    at_sample();
    chk("rd_full_count", int'(fifo_count), 2);
    step(); redirect_valid = 1'b1; redirect_pc = 4'd9;
    at_sample();
    chk("rd_cycle_req", int'(imem_req), 0);
    step(); redirect_valid = 1'b0; out_ready = 1'b1;
    at_sample();
    chk("rd_flush_count", int'(fifo_count), 0);
    chk("rd_flush_valid", int'(out_valid), 0);
    chk("rd_next_addr", int'(imem_addr), 9);
    step(); at_sample();
    chk("rd_gap_valid", int'(out_valid), 0);
    step(); at_sample();
    chk("rd_first_pc", int'(out_pc), 9);
    chk("rd_first_instr", int'(out_instr), int'(mem[9]));

    // Halt while streaming: in-flight work drains, fetch resumes in sequence.
    repeat (3) step();
    at_sample();
    chk("halt_pre_req", int'(imem_req), 1);
    last_addr = int'(imem_addr);
    step(); halt = 1'b1;
    delivered = 0;
    for (int i = 0; i < 5; i++) begin
      at_sample();
      if (out_valid && out_ready) delivered++;
      step();
    end
    halt = 1'b0;
    at_sample();
    chk("halt_delivered", delivered, DEPTH);
    chk("halt_resume_req", int'(imem_req), 1);
    chk("halt_resume_addr", int'(imem_addr), (last_addr + 1) % NPC);

    // Asynchronous reset mid-stream with a full buffer.
    step(); out_ready = 1'b0;
    repeat (3) step();
    at_sample();
    chk("ar_full_count", int'(fifo_count), 2);
    step(); reset = 1'b0;
    #1;
    chk("ar_async_valid", int'(out_valid), 0);
    chk("ar_async_count", int'(fifo_count), 0);
    step(); reset = 1'b1; out_ready = 1'b1;
    at_sample();
    chk("ar_first_req", int'(imem_req), 1);
    chk("ar_first_addr", int'(imem_addr), 0);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      step();
      out_ready      = ($urandom_range(0, 9) < 7);
      halt           = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = ADDR_W'($urandom_range(0, NPC - 1));
      reset          = !($urandom_range(0, 199) == 0);
    end
    step();
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
